router_input_arbiter: RTL and testbench
=======================================

// Module: router_input_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single router input port (valid/data/ready) among NUM_REQ sources.
//  Sits directly in front of the router. Each source presents a complete [addr|data] word.
//  Each cycle the arbiter grants at most one source and registers that word into a one-entry output stage.
//  The output stage drives the router input. Fair, starvation-free, one word per grant.
// PARAMETERS
//  NUM_REQ    4   number of requesting sources (>=2)
//  DATA_WIDTH 10  word width, [ADDR_W|DATA_W] format, passed through unmodified
//  STAT_W     16  width of per-source grant counters (ARB_STATS_EN only)
// PORTS
//  clk_i        in   1                  clock, all logic on rising edge
//  rst_i        in   1                  asynchronous reset, active-high
//  req_valid_i  in   NUM_REQ            per-source word valid
//  req_data_i   in   NUM_REQ*DATA_WIDTH per-source word [addr|data]
//  req_ready_o  out  NUM_REQ            per-source accept, at most one bit high (one-hot or zero)
//  out_valid_o  out  1                  registered word valid toward router
//  out_data_o   out  DATA_WIDTH         registered word toward router
//  out_ready_i  in   1                  router can accept (router ready)
//  grant_id_o   out  $clog2(NUM_REQ)    source index of the word on out_data_o
//  stat_clr_i   in   1                  sync clear of grant counters (ARB_STATS_EN only)
//  grant_cnt_o  out  NUM_REQ*STAT_W     per-source grant counters (ARB_STATS_EN only)
// BEHAVIOUR
//  Reset (async, while rst_i=1):
//   - out_valid_o=0, out_data_o=0, grant_id_o=0.
//   - last_grant=NUM_REQ-1, so after reset source 0 has top priority.
//   - grant_cnt_o=0.
//   - req_ready_o forced to 0.
//  Output stage: out_valid_o, out_data_o and grant_id_o come straight from flops; no combinational path from req_*_i to out_*_o.
//  Transfer to router: happens when out_valid_o && out_ready_i at a clock edge.
//   - While out_valid_o=1 and out_ready_i=0, out_data_o and grant_id_o stay stable.
//  slot_free = ~out_valid_o | out_ready_i. The output stage may reload in the same cycle it drains, giving full throughput.
//  Arbitration (combinational, every cycle):
//   - If slot_free and |req_valid_i: g = first index with req_valid_i set, searching circularly from last_grant+1.
//   - req_ready_o = one-hot(g) in that case, else 0.
//   - The source sees ready in the same cycle as its valid (valid/ready handshake; source must hold valid/data until ready).
//  On accept edge (slot_free && |req_valid_i):
//   - out_data_o <= req_data_i[g]; grant_id_o <= g; out_valid_o <= 1; last_grant <= g.
//  Drain without new request (out_valid_o && out_ready_i && ~|req_valid_i): out_valid_o <= 0; data and id hold their last value.
//  last_grant changes only on an accept. Stalls and idle cycles do not rotate priority.
//  Fairness bound: a continuously valid source is granted within NUM_REQ accepts.
//  Latency: request accepted at edge N -> out_valid_o=1 from edge N; router consumes it at the first edge with out_ready_i=1.
//  Wrap-around: search index and last_grant wrap modulo NUM_REQ.
//   - For non-power-of-2 NUM_REQ, indices >= NUM_REQ are never produced.
//  Single requester: that source is granted back-to-back every cycle that slot_free=1.
//  Reset mid-operation: an in-flight word in the output stage is discarded (not delivered). No partial state survives.
//  Payload is not inspected. The addr field is passed through; routing is the router's job.
// CONFIGURATION
//  ARB_STATS_EN defined:
//   - stat_clr_i and grant_cnt_o exist.
//   - grant_cnt_o[g] += 1 on every accept of source g; saturates at 2^STAT_W-1 (no wrap).
//   - stat_clr_i=1 zeroes all counters at the next edge; clear wins over a simultaneous increment.
//  ARB_STATS_EN undefined: those ports and counters are absent. Arbitration behaviour is identical.
// TESTING
//  1 Reset: rst_i=1 with req_valid_i=4'hF -> req_ready_o=0, out_valid_o=0, out_data_o=0; after release, first grant goes to source 0.
//  2 All four valid, out_ready_i=1 held -> grant_id_o sequence 0,1,2,3,0,1...; one word per cycle; each out_data_o equals the granted req_data_i.
//  3 Backpressure: out_valid_o=1 with data 10'h2A5, out_ready_i=0 for 5 cycles -> req_ready_o=0 and out_data_o stable; on out_ready_i=1 the next source is granted that same cycle.
//  4 Sparse: only source 2 valid, then sources 1 and 3 valid together -> grant 2, then 3 (circular after 2), then 1; last_grant does not change on idle cycles.
//  5 Reset mid-stream: rst_i pulsed while out_valid_o=1 -> out_valid_o=0 immediately (async); restart grants source 0 first.
//  6 ARB_STATS_EN with STAT_W=4: 20 grants to source 1 -> grant_cnt_o[1]=4'hF (saturated); stat_clr_i on a grant cycle -> counter reads 0.

Source files
------------

// File: rtl/router_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : router_input_arbiter
// Purpose  : Round-robin arbiter sharing one router input port among NUM_REQ
//            sources. Each cycle at most one source is granted and its
//            [addr|data] word is registered into a one-entry output stage
//            that drives the router. The output stage may reload in the same
//            cycle it drains, giving one word per cycle at full throughput.
// Ports    : clk_i, rst_i        clock / asynchronous active-high reset
//            req_valid_i         per-source word valid
//            req_data_i          per-source words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//            req_ready_o         per-source accept (one-hot or zero)
//            out_valid_o         registered word valid toward router
//            out_data_o          registered word toward router
//            out_ready_i         router ready
//            grant_id_o          source index of the word on out_data_o
//            stat_clr_i          synchronous clear of grant counters (ARB_STATS_EN)
//            grant_cnt_o         saturating per-source grant counters (ARB_STATS_EN)
// Options  : define ARB_STATS_EN to add the grant counters and their ports.
// Revision : 1.0 - initial release
// ============================================================================
module router_input_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 10,
  parameter int STAT_W     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  input  logic                          out_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o
`ifdef ARB_STATS_EN
  ,
  input  logic                          stat_clr_i,
  output logic [NUM_REQ*STAT_W-1:0]     grant_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;

  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand_idx;
  int                    cand;
  logic                  slot_free;
  logic                  accept;
  logic [NUM_REQ-1:0]    ready_vec;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_word[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Circular search starting just after the last granted source. The modulo
  // keeps candidate indices inside 0..NUM_REQ-1 for any NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found && req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // rst_i gates the handshake so no source believes it was accepted while
  // the output stage is held in reset.
  assign slot_free = ~out_valid_q | out_ready_i;
  assign accept    = slot_free & grant_found & ~rst_i;

  always_comb begin
    ready_vec            = '0;
    ready_vec[grant_idx] = accept;
  end

  assign req_ready_o = ready_vec;

  // Next state of the output stage and priority pointer. The pointer moves
  // only on an accept, so stalls and idle cycles leave priority untouched.
  always_comb begin
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    grant_id_d   = grant_id_q;
    if (accept) begin
      last_grant_d = grant_idx;
      out_valid_d  = 1'b1;
      out_data_d   = req_word[grant_idx];
      grant_id_d   = grant_idx;
    end else if (out_ready_i) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      grant_id_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign grant_id_o  = grant_id_q;

`ifdef ARB_STATS_EN
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
      logic [STAT_W-1:0] cnt_q, cnt_d;

      // Clear has priority over a same-cycle increment; counting stops at
      // all-ones instead of wrapping.
      always_comb begin
        cnt_d = cnt_q;
        if (stat_clr_i) begin
          cnt_d = '0;
        end else if (accept && (grant_idx == IDX_W'(i)) && (cnt_q != {STAT_W{1'b1}})) begin
          cnt_d = cnt_q + STAT_W'(1);
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign grant_cnt_o[i*STAT_W +: STAT_W] = cnt_q;
    end
  endgenerate
`else
  localparam int STAT_W_UNUSED = STAT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_input_arbiter
// Purpose  : Self-checking bench for router_input_arbiter. A cycle-level
//            model (circular priority search over plain integers) predicts
//            ready, output stage and grant counters every cycle; directed
//            steps add literal expectations for reset, rotation,
//            backpressure, sparse requests, mid-stream reset and counter
//            saturation/clear (the latter when ARB_STATS_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_input_arbiter;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int IW = 2;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic [IW-1:0] grant_id;
`ifdef ARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [N*SW-1:0] grant_cnt;
`endif

  int checks = 0;
  int passes = 0;

  logic [W-1:0] dat [N];

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  router_input_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(W),
    .STAT_W    (SW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_ready_o(req_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready),
    .grant_id_o (grant_id)
`ifdef ARB_STATS_EN
    ,
    .stat_clr_i (stat_clr),
    .grant_cnt_o(grant_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int           m_last, p_last;
  bit           m_v, p_v;
  logic [W-1:0] m_d, p_d;
  int           m_id, p_id;
  int           m_cnt [N];
  int           p_cnt [N];
  bit           pend;
  int           g;
  int           exp_rdy;

  initial begin
    m_last = N - 1; m_v = 0; m_d = '0; m_id = 0; pend = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_last = N - 1; m_v = 0; m_d = '0; m_id = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_id", grant_id, 0);
        pend = 0;
      end else begin
        chk("m_valid", out_valid, m_v);
        if (m_v) begin
          chk("m_data", out_data, m_d);
          chk("m_id", grant_id, m_id);
        end
`ifdef ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("m_cnt", grant_cnt[i*SW +: SW], m_cnt[i]);
`endif
        g = -1;
        if (!m_v || out_ready) begin
          for (int k = 1; k <= N; k++) begin
            if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
          end
        end
        exp_rdy = (g >= 0) ? (1 << g) : 0;
        chk("m_ready", req_ready, exp_rdy);
        p_last = m_last; p_v = m_v; p_d = m_d; p_id = m_id;
        for (int i = 0; i < N; i++) p_cnt[i] = m_cnt[i];
        if (g >= 0) begin
          p_last = g; p_v = 1; p_d = req_data[g*W +: W]; p_id = g;
          if (p_cnt[g] < (1 << SW) - 1) p_cnt[g]++;
        end else if (out_ready) begin
          p_v = 0;
        end
`ifdef ARB_STATS_EN
        if (stat_clr) for (int i = 0; i < N; i++) p_cnt[i] = 0;
`endif
        pend = 1;
      end
      @(posedge clk);
      if (!rst && pend) begin
        m_last = p_last; m_v = p_v; m_d = p_d; m_id = p_id;
        for (int i = 0; i < N; i++) m_cnt[i] = p_cnt[i];
      end
      pend = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [4:0] tbl [12];

  initial begin
    dat[0] = 10'h011; dat[1] = 10'h122; dat[2] = 10'h2A5; dat[3] = 10'h3F3;
    tbl = '{5'b1_1111, 5'b0_1111, 5'b0_0101, 5'b1_0101, 5'b1_0000, 5'b1_1001,
            5'b1_1001, 5'b0_0000, 5'b1_0110, 5'b1_1000, 5'b1_0001, 5'b1_1110};

    // Reset with every source requesting
    rst = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
    tick(); tick();
    chk("lit_rst_ready", req_ready, 4'b0000);
    chk("lit_rst_valid", out_valid, 1'b0);
    chk("lit_rst_data", out_data, 10'h000);
    rst = 1'b0;
    #1;
    chk("lit_first_ready", req_ready, 4'b0001);

    // Full rotation, one word per cycle
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("lit_rr_id", grant_id, i % N);
      chk("lit_rr_data", out_data, dat[i % N]);
      chk("lit_rr_valid", out_valid, 1'b1);
    end

    // Backpressure holding 10'h2A5
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("lit_bp_ready", req_ready, 4'b0000);
      chk("lit_bp_data", out_data, 10'h2A5);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("lit_bp_release_ready", req_ready, 4'b1000);
    tick();
    chk("lit_bp_next_id", grant_id, 3);
    chk("lit_bp_next_data", out_data, 10'h3F3);

    // Sparse requests; idle cycles must not rotate priority
    req_valid = 4'b0000;
    tick();
    chk("lit_drain_valid", out_valid, 1'b0);
    chk("lit_drain_id_hold", grant_id, 3);
    tick(); tick();
    req_valid = 4'b0100;
    tick();
    chk("lit_sparse_2", grant_id, 2);
    req_valid = 4'b1010;
    tick();
    chk("lit_sparse_3", grant_id, 3);
    req_valid = 4'b0010;
    tick();
    chk("lit_sparse_1", grant_id, 1);
    chk("lit_sparse_1_data", out_data, 10'h122);
    req_valid = 4'b0000;
    tick(); tick(); tick();
    req_valid = 4'hF;
    tick();
    chk("lit_idle_keeps_prio", grant_id, 2);
    out_ready = 1'b0;

    // Reset while a word sits in the output stage
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("lit_midrst_valid", out_valid, 1'b0);
    chk("lit_midrst_ready", req_ready, 4'b0000);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("lit_restart_ready", req_ready, 4'b0001);
    tick();
    chk("lit_restart_id", grant_id, 0);
    chk("lit_restart_data", out_data, 10'h011);

    // Single requester granted back-to-back
    req_valid = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lit_single_id", grant_id, 1);
      chk("lit_single_valid", out_valid, 1'b1);
    end
`ifdef ARB_STATS_EN
    chk("lit_cnt1_sat", grant_cnt[1*SW +: SW], 4'hF);
    chk("lit_cnt0", grant_cnt[0*SW +: SW], 4'h1);
    stat_clr = 1'b1;
    tick();
    chk("lit_clr_cnt1", grant_cnt[1*SW +: SW], 4'h0);
    chk("lit_clr_cnt0", grant_cnt[0*SW +: SW], 4'h0);
    stat_clr = 1'b0;
    tick();
    chk("lit_after_clr_cnt1", grant_cnt[1*SW +: SW], 4'h1);
`endif

    // Mixed ready/valid patterns checked by the model
    for (int i = 0; i < 12; i++) begin
      {out_ready, req_valid} = tbl[i];
      tick();
    end
    req_valid = 4'b0000; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
